perf_counter_ctrl: RTL
======================

Name: perf_counter_ctrl

Overview:
Controller for a bank of NUM_CNT performance counters, each accumulating a per-cycle event step. It sequences the counters with START, STOP, CLEAR and DUMP commands over a valid/ready command port. DUMP snapshots all counters in one cycle and drains the values serially over a valid/ready read port. The block sits beside the accelerator datapath and is driven by the host/CSR interface for profiling.

Parameters:
NUM_CNT, 4, number of counters (>=2).
DATA_WIDTH, 32, bits per counter.
STEP_BITWIDTH, 8, bits per event step.
ID_WIDTH, 2, counter index width (= clog2(NUM_CNT)).

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  synchronous, active-high reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  command accepted when valid&ready.
cmd_op  in  2  00 START, 01 STOP, 10 CLEAR, 11 DUMP.
evt_en  in  NUM_CNT  per-counter event strobe, sampled each cycle.
evt_step  in  NUM_CNT*STEP_BITWIDTH  per-counter increment; counter i uses slice [i*STEP_BITWIDTH +: STEP_BITWIDTH].
rd_valid  out  1  snapshot word valid.
rd_ready  in  1  consumer accepts word.
rd_id  out  ID_WIDTH  index of the current word.
rd_data  out  DATA_WIDTH  snapshot value.
rd_last  out  1  high with the word for index NUM_CNT-1.
running  out  1  counters enabled.
busy  out  1  drain in progress.
ovf  out  NUM_CNT  sticky wrap flag per counter.

Behaviour:
- Reset: counters=0, snapshots=0, ovf=0, running=0, busy=0, rd_valid=0, rd_id=0, rd_data=0, rd_last=0, cmd_ready=1, run-state=STOPPED, drain-state=IDLE.
- Run state (STOPPED/RUNNING) and drain state (IDLE/DRAIN) are independent; counters keep counting during a drain.
- Counting: while running=1, counter i <= counter i + zero-extended step_i whenever evt_en[i]=1. A step of 0 is legal and leaves the counter unchanged. Modulo 2^DATA_WIDTH; a carry out sets ovf[i], which stays set until CLEAR or rst.
- Commands are accepted on the valid&ready edge and take effect at that edge.
  - START: running=1 from the next cycle. A START while already running is a no-op.
  - STOP: running=0 from the next cycle. Events in the accepting cycle still count if the block was running.
  - CLEAR: all counters and ovf go to 0 at the edge. Any event in the same cycle is discarded. Run state is unchanged.
  - DUMP: all NUM_CNT counter values (pre-increment, as of the accepting cycle) are copied into the snapshot registers. Drain state goes to DRAIN, busy=1, and rd_valid=1 with rd_id=0 on the next cycle.
- cmd_ready=0 while busy=1. Commands are not queued; the requester holds cmd_valid.
- Drain: rd_data = snapshot[rd_id]. rd_valid, rd_id and rd_data are held stable until rd_valid&rd_ready.
  - On a handshake, rd_id increments.
  - On the handshake with rd_last=1, next cycle: rd_valid=0, busy=0, rd_id=0, cmd_ready=1.
  - Back-to-back handshakes give one word per cycle, so the minimum drain is NUM_CNT cycles.
- rst asserted mid-drain aborts immediately: rd_valid=0 next cycle and all state takes its reset value.
- rd_ready is ignored while rd_valid=0.

Test Plan:
1. rst, then START, hold evt_en=4'b0101 with steps {0,3,0,5} (counters 3..0) for 10 cycles, STOP, DUMP with rd_ready=1 -> words id0..3 = 50,0,30,0 on consecutive cycles; rd_last only on id3; busy falls the cycle after.
2. DATA_WIDTH=8: preload via 255 steps of 1 on counter 0, then one step of 2 -> counter0=1, ovf[0]=1. CLEAR -> counter0=0, ovf=0.
3. DUMP while running with counter1 incrementing by 1 every cycle, rd_ready toggling 1-0-0-1 -> all words are the values from the accept cycle; rd_data/rd_id stable while stalled; live counter1 keeps advancing (verified by a second DUMP).
4. Assert cmd_valid with START during a drain -> cmd_ready=0 until drain ends; START is accepted the cycle busy=0.
5. CLEAR and evt_en[2]=1 with step 7 in the same accepting cycle -> counter2=0 afterwards; STOP with a same-cycle event -> the event is counted.
6. Assert rst at the second drain word -> next cycle rd_valid=0, busy=0, running=0, counters=0; a subsequent DUMP returns all zeros.

Source files
------------

// File: rtl/perf_counter_ctrl.sv
// rtl/perf_counter_ctrl.sv - performance counter bank with command sequencing and serial snapshot drain
//
// Purpose: NUM_CNT event counters accumulate a per-cycle step while running.
// START/STOP/CLEAR/DUMP arrive over a valid/ready command port. DUMP freezes
// every counter into a snapshot bank in one cycle, then the snapshot is
// drained one word per handshake over a valid/ready read port.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cmd_valid/ready/op  command handshake; op 00 START, 01 STOP, 10 CLEAR, 11 DUMP
//   evt_en, evt_step    per-counter event strobe and packed step values
//   rd_valid/ready      snapshot word handshake
//   rd_id, rd_data      index and value of the current snapshot word
//   rd_last             marks the word for index NUM_CNT-1
//   running, busy       counters enabled / drain in progress
//   ovf                 sticky per-counter wrap flags
module perf_counter_ctrl #(
  parameter int NUM_CNT       = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int STEP_BITWIDTH = 8,
  parameter int ID_WIDTH      = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [1:0]                       cmd_op,
  input  logic [NUM_CNT-1:0]               evt_en,
  input  logic [NUM_CNT*STEP_BITWIDTH-1:0] evt_step,
  output logic                             rd_valid,
  input  logic                             rd_ready,
  output logic [ID_WIDTH-1:0]              rd_id,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             rd_last,
  output logic                             running,
  output logic                             busy,
  output logic [NUM_CNT-1:0]               ovf
);

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_DUMP  = 2'b11;
  localparam int SUM_W = DATA_WIDTH + 1;
  localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_CNT - 1);

  typedef enum logic {RUN_STOPPED, RUN_RUNNING} run_state_e;
  typedef enum logic {DRN_IDLE, DRN_DRAIN} drain_state_e;

  run_state_e          run_q;
  drain_state_e        drain_q;
  logic [ID_WIDTH-1:0] rd_id_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                rd_last_q;

  logic [DATA_WIDTH-1:0] cnt_q  [NUM_CNT];
  logic [DATA_WIDTH-1:0] cnt_d  [NUM_CNT];
  logic [DATA_WIDTH-1:0] snap_q [NUM_CNT];
  logic [SUM_W-1:0]      sum    [NUM_CNT];
  logic [NUM_CNT-1:0]    ovf_q;
  logic [NUM_CNT-1:0]    ovf_d;

  logic                cmd_fire;
  logic                clear_fire;
  logic                dump_fire;
  logic [ID_WIDTH-1:0] next_id;

  assign running   = (run_q == RUN_RUNNING);
  assign busy      = (drain_q == DRN_DRAIN);
  assign rd_valid  = busy;
  assign cmd_ready = ~busy;
  assign rd_id     = rd_id_q;
  assign rd_data   = rd_data_q;
  assign rd_last   = rd_last_q;
  assign ovf       = ovf_q;

  assign cmd_fire   = cmd_valid & cmd_ready;
  assign clear_fire = cmd_fire & (cmd_op == OP_CLEAR);
  assign dump_fire  = cmd_fire & (cmd_op == OP_DUMP);
  assign next_id    = rd_id_q + ID_WIDTH'(1);

  // CLEAR wins over a same-cycle event; the carry bit of the widened sum
  // is the wrap indication for the sticky flag.
  always_comb begin
    ovf_d = ovf_q;
    for (int i = 0; i < NUM_CNT; i++) begin
      sum[i]   = {1'b0, cnt_q[i]} + SUM_W'(evt_step[i*STEP_BITWIDTH +: STEP_BITWIDTH]);
      cnt_d[i] = cnt_q[i];
      if (clear_fire) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (running && evt_en[i]) begin
        cnt_d[i] = sum[i][DATA_WIDTH-1:0];
        if (sum[i][DATA_WIDTH]) ovf_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= '0;
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i]  <= '0;
        snap_q[i] <= '0;
      end
    end else begin
      ovf_q <= ovf_d;
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i] <= cnt_d[i];
        // Snapshot takes the pre-increment value of the accepting cycle.
        if (dump_fire) snap_q[i] <= cnt_q[i];
      end
    end
  end

  // Run and drain state machines advance independently.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q     <= RUN_STOPPED;
      drain_q   <= DRN_IDLE;
      rd_id_q   <= '0;
      rd_data_q <= '0;
      rd_last_q <= 1'b0;
    end else begin
      case (run_q)
        RUN_STOPPED: if (cmd_fire && cmd_op == OP_START) run_q <= RUN_RUNNING;
        RUN_RUNNING: if (cmd_fire && cmd_op == OP_STOP)  run_q <= RUN_STOPPED;
        default:     run_q <= RUN_STOPPED;
      endcase
      case (drain_q)
        DRN_IDLE: begin
          if (dump_fire) begin
            drain_q   <= DRN_DRAIN;
            rd_id_q   <= '0;
            // snap_q loads on this same edge, so word 0 comes from the live counter.
            rd_data_q <= cnt_q[0];
            rd_last_q <= 1'b0;
          end
        end
        DRN_DRAIN: begin
          if (rd_ready) begin
            if (rd_last_q) begin
              drain_q   <= DRN_IDLE;
              rd_id_q   <= '0;
              rd_data_q <= '0;
              rd_last_q <= 1'b0;
            end else begin
              rd_id_q   <= next_id;
              rd_data_q <= snap_q[next_id];
              rd_last_q <= (next_id == LAST_ID);
            end
          end
        end
        default: drain_q <= DRN_IDLE;
      endcase
    end
  end

endmodule
